// File: rtl/axi_rd_arbiter.sv
// Two-master round-robin AXI4 read-channel arbiter, one outstanding transaction.
// The grant is held from AR issue to the last R beat; rlast is checked against arlen.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_reset,
  // instruction master
  input  logic [ADDR_WIDTH-1:0] inst_araddr,
  input  logic [2:0]            inst_arsize,
  input  logic [1:0]            inst_arburst,
  input  logic [7:0]            inst_arlen,
  input  logic                  inst_arvalid,
  output logic                  inst_arready,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  output logic                  inst_rvalid,
  output logic                  inst_rlast,
  input  logic                  inst_rready,
  // data master
  input  logic [ADDR_WIDTH-1:0] mem_araddr,
  input  logic [2:0]            mem_arsize,
  input  logic [1:0]            mem_arburst,
  input  logic [7:0]            mem_arlen,
  input  logic                  mem_arvalid,
  output logic                  mem_arready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rvalid,
  output logic                  mem_rlast,
  input  logic                  mem_rready,
  // slave port
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [2:0]            s_arsize,
  output logic [1:0]            s_arburst,
  output logic [7:0]            s_arlen,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  s_rvalid,
  input  logic                  s_rlast,
  output logic                  s_rready,
  output logic                  rd_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR   = 2'd1;
  localparam logic [1:0] R    = 2'd2;

  localparam logic G_INST = 1'b0;
  localparam logic G_MEM  = 1'b1;

  logic [1:0]            state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  rd_err_q, rd_err_d;
  logic                  s_arvalid_q, s_arvalid_d;
  logic [ADDR_WIDTH-1:0] s_araddr_q, s_araddr_d;
  logic [2:0]            s_arsize_q, s_arsize_d;
  logic [1:0]            s_arburst_q, s_arburst_d;
  logic [7:0]            s_arlen_q, s_arlen_d;

  logic sel_c;
  logic any_req_c;
  logic in_idle_c;
  logic in_r_c;
  logic rready_c;
  logic beat_c;

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    sel_c = G_INST;
    if (inst_arvalid && mem_arvalid) begin
      sel_c = ~last_grant_q;
    end else if (mem_arvalid) begin
      sel_c = G_MEM;
    end
  end

  assign any_req_c = inst_arvalid | mem_arvalid;
  assign in_idle_c = (state_q == IDLE);
  assign in_r_c    = (state_q == R);

  assign inst_arready = in_idle_c && any_req_c && (sel_c == G_INST);
  assign mem_arready  = in_idle_c && any_req_c && (sel_c == G_MEM);

  // R channel is routed only to the granted master and only while in R.
  assign rready_c = in_r_c && ((grant_q == G_INST) ? inst_rready : mem_rready);
  assign beat_c   = s_rvalid && rready_c;

  assign s_rready    = rready_c;
  assign inst_rvalid = in_r_c && (grant_q == G_INST) && s_rvalid;
  assign inst_rlast  = in_r_c && (grant_q == G_INST) && s_rlast;
  assign inst_rdata  = (in_r_c && (grant_q == G_INST)) ? s_rdata : '0;
  assign mem_rvalid  = in_r_c && (grant_q == G_MEM) && s_rvalid;
  assign mem_rlast   = in_r_c && (grant_q == G_MEM) && s_rlast;
  assign mem_rdata   = (in_r_c && (grant_q == G_MEM)) ? s_rdata : '0;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    rd_err_d     = rd_err_q;
    s_arvalid_d  = s_arvalid_q;
    s_araddr_d   = s_araddr_q;
    s_arsize_d   = s_arsize_q;
    s_arburst_d  = s_arburst_q;
    s_arlen_d    = s_arlen_q;

    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          grant_d     = sel_c;
          s_arvalid_d = 1'b1;
          state_d     = AR;
          if (sel_c == G_MEM) begin
            s_araddr_d  = mem_araddr;
            s_arsize_d  = mem_arsize;
            s_arburst_d = mem_arburst;
            s_arlen_d   = mem_arlen;
          end else begin
            s_araddr_d  = inst_araddr;
            s_arsize_d  = inst_arsize;
            s_arburst_d = inst_arburst;
            s_arlen_d   = inst_arlen;
          end
        end
      end
      AR: begin
        if (s_arready) begin
          s_arvalid_d = 1'b0;
          beat_cnt_d  = 8'd0;
          state_d     = R;
        end
      end
      R: begin
        if (beat_c) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // Early rlast or a missing rlast on the final beat both flag an error.
          if ((s_rlast && (beat_cnt_q != s_arlen_q)) ||
              (!s_rlast && (beat_cnt_q == s_arlen_q))) begin
            rd_err_d = 1'b1;
          end
          if (s_rlast) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      state_q      <= IDLE;
      grant_q      <= G_INST;
      last_grant_q <= G_MEM;
      beat_cnt_q   <= 8'd0;
      rd_err_q     <= 1'b0;
      s_arvalid_q  <= 1'b0;
      s_araddr_q   <= '0;
      s_arsize_q   <= 3'd0;
      s_arburst_q  <= 2'd0;
      s_arlen_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_err_q     <= rd_err_d;
      s_arvalid_q  <= s_arvalid_d;
      s_araddr_q   <= s_araddr_d;
      s_arsize_q   <= s_arsize_d;
      s_arburst_q  <= s_arburst_d;
      s_arlen_q    <= s_arlen_d;
    end
  end

  assign s_arvalid = s_arvalid_q;
  assign s_araddr  = s_araddr_q;
  assign s_arsize  = s_arsize_q;
  assign s_arburst = s_arburst_q;
  assign s_arlen   = s_arlen_q;
  assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: arbitration order, AR stall, burst routing,
// rlast/arlen error detection and mid-burst reset.
module tb_axi_rd_arbiter;

  logic        cpu_clk;
  logic        cpu_reset;
  logic [31:0] inst_araddr;
  logic [2:0]  inst_arsize;
  logic [1:0]  inst_arburst;
  logic [7:0]  inst_arlen;
  logic        inst_arvalid;
  logic        inst_arready;
  logic [31:0] inst_rdata;
  logic        inst_rvalid;
  logic        inst_rlast;
  logic        inst_rready;
  logic [31:0] mem_araddr;
  logic [2:0]  mem_arsize;
  logic [1:0]  mem_arburst;
  logic [7:0]  mem_arlen;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_rlast;
  logic        mem_rready;
  logic [31:0] s_araddr;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic [7:0]  s_arlen;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic        s_rlast;
  logic        s_rready;
  logic        rd_err;

  int checks;
  int errors;

  axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset),
    .inst_araddr(inst_araddr), .inst_arsize(inst_arsize), .inst_arburst(inst_arburst),
    .inst_arlen(inst_arlen), .inst_arvalid(inst_arvalid), .inst_arready(inst_arready),
    .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rlast(inst_rlast),
    .inst_rready(inst_rready),
    .mem_araddr(mem_araddr), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
    .mem_arlen(mem_arlen), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rlast(mem_rlast),
    .mem_rready(mem_rready),
    .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlen(s_arlen),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .s_rlast(s_rlast), .s_rready(s_rready), .rd_err(rd_err)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow after one more unit.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    cpu_reset = 1'b1;
    tick();
    tick();
    cpu_reset = 1'b0;
  endtask

  // Single-beat read from IDLE with the requesters already driven by the caller.
  task automatic txn(input logic exp_mem, input logic [31:0] exp_addr, input logic [31:0] data);
    #1;
    chk1("arready_inst", inst_arready, ~exp_mem);
    chk1("arready_mem", mem_arready, exp_mem);
    tick();
    s_arready = 1'b1;
    #1;
    chk1("s_arvalid_set", s_arvalid, 1'b1);
    chk32("s_araddr", s_araddr, exp_addr);
    chk1("arready_none_ar", inst_arready | mem_arready, 1'b0);
    tick();
    s_rvalid = 1'b1; s_rdata = data; s_rlast = 1'b1;
    inst_rready = 1'b1; mem_rready = 1'b1;
    #1;
    chk1("s_arvalid_clr", s_arvalid, 1'b0);
    chk1("inst_rvalid", inst_rvalid, ~exp_mem);
    chk1("mem_rvalid", mem_rvalid, exp_mem);
    chk32("inst_rdata", inst_rdata, exp_mem ? 32'h0 : data);
    chk32("mem_rdata", mem_rdata, exp_mem ? data : 32'h0);
    chk1("s_rready", s_rready, 1'b1);
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = 32'h0;
  endtask

  initial begin
    logic [5:0] pat;
    int k;
    int delivered;
    checks = 0; errors = 0;
    cpu_reset = 1'b0;
    inst_araddr = 32'h0; inst_arsize = 3'd0; inst_arburst = 2'd0; inst_arlen = 8'd0;
    inst_arvalid = 1'b0; inst_rready = 1'b0;
    mem_araddr = 32'h0; mem_arsize = 3'd0; mem_arburst = 2'd0; mem_arlen = 8'd0;
    mem_arvalid = 1'b0; mem_rready = 1'b0;
    s_arready = 1'b0; s_rdata = 32'h0; s_rvalid = 1'b0; s_rlast = 1'b0;

    // Reset values
    do_reset();
    #1;
    chk1("rst_s_arvalid", s_arvalid, 1'b0);
    chk32("rst_s_araddr", s_araddr, 32'h0);
    chk1("rst_rd_err", rd_err, 1'b0);
    chk1("rst_s_rready", s_rready, 1'b0);
    chk1("rst_arready", inst_arready | mem_arready, 1'b0);

    // Single INST read
    inst_arvalid = 1'b1; inst_araddr = 32'h0000_1000; inst_arlen = 8'd0;
    inst_arsize = 3'd2; inst_arburst = 2'd1;
    txn(1'b0, 32'h0000_1000, 32'hDEAD_BEEF);
    inst_arvalid = 1'b0;
    #1;
    chk32("t1_arsize", 32'(s_arsize), 32'd2);
    chk32("t1_arburst", 32'(s_arburst), 32'd1);
    chk1("t1_rd_err", rd_err, 1'b0);
    chk1("t1_rvalid_idle", inst_rvalid, 1'b0);

    // Both requesting: strict alternation starting with INST
    do_reset();
    inst_arvalid = 1'b1; inst_araddr = 32'h0000_2000;
    mem_arvalid = 1'b1; mem_araddr = 32'h0000_3000; mem_arlen = 8'd0;
    txn(1'b0, 32'h0000_2000, 32'h1111_1111);
    txn(1'b1, 32'h0000_3000, 32'h2222_2222);
    txn(1'b0, 32'h0000_2000, 32'h3333_3333);
    txn(1'b1, 32'h0000_3000, 32'h4444_4444);
    inst_arvalid = 1'b0; mem_arvalid = 1'b0;

    // AR stall: s_arready low for 5 cycles, MEM request ignored meanwhile
    s_arready = 1'b0;
    inst_arvalid = 1'b1; inst_araddr = 32'h0000_4000; inst_arlen = 8'd0;
    #1;
    chk1("t3_inst_arready", inst_arready, 1'b1);
    tick();
    inst_arvalid = 1'b0;
    mem_arvalid = 1'b1; mem_araddr = 32'h0000_5000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1("t3_s_arvalid_hold", s_arvalid, 1'b1);
      chk32("t3_s_araddr_hold", s_araddr, 32'h0000_4000);
      chk1("t3_no_arready", inst_arready | mem_arready, 1'b0);
      tick();
    end
    s_arready = 1'b1;
    tick();
    s_rvalid = 1'b1; s_rdata = 32'hA5A5_A5A5; s_rlast = 1'b1; inst_rready = 1'b1;
    #1;
    chk32("t3_inst_rdata", inst_rdata, 32'hA5A5_A5A5);
    chk1("t3_mem_arready_r", mem_arready, 1'b0);
    mem_arvalid = 1'b0;
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;

    // MEM 4-beat burst with mem_rready back-pressure
    mem_arvalid = 1'b1; mem_araddr = 32'h0000_6000; mem_arlen = 8'd3;
    mem_arsize = 3'd1; mem_arburst = 2'd2;
    #1;
    chk1("t4_mem_arready", mem_arready, 1'b1);
    tick();
    mem_arvalid = 1'b0;
    #1;
    chk32("t4_s_arlen", 32'(s_arlen), 32'd3);
    chk32("t4_s_arsize", 32'(s_arsize), 32'd1);
    chk32("t4_s_arburst", 32'(s_arburst), 32'd2);
    tick();
    pat = 6'b101101;
    k = 0;
    delivered = 0;
    for (int c = 0; c < 6; c++) begin
      s_rvalid = 1'b1;
      s_rdata = 32'h10 + 32'(k);
      s_rlast = (k == 3);
      mem_rready = pat[c];
      #1;
      chk1("t4_mem_rvalid", mem_rvalid, 1'b1);
      chk32("t4_mem_rdata", mem_rdata, 32'h10 + 32'(k));
      chk1("t4_s_rready", s_rready, pat[c]);
      chk1("t4_inst_rvalid", inst_rvalid, 1'b0);
      if (mem_rvalid && mem_rready) delivered++;
      if (pat[c]) k++;
      tick();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; mem_rready = 1'b0;
    #1;
    chk32("t4_beats", 32'(delivered), 32'd4);
    chk1("t4_rd_err", rd_err, 1'b0);
    chk1("t4_s_rready_idle", s_rready, 1'b0);

    // arlen=3 but rlast on the 2nd beat
    inst_arvalid = 1'b1; inst_araddr = 32'h0000_7000; inst_arlen = 8'd3;
    #1;
    chk1("t5_inst_arready", inst_arready, 1'b1);
    tick();
    inst_arvalid = 1'b0;
    tick();
    s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = 32'h1; inst_rready = 1'b1;
    tick();
    #1;
    chk1("t5_no_err_yet", rd_err, 1'b0);
    s_rlast = 1'b1; s_rdata = 32'h2;
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    chk1("t5_rd_err", rd_err, 1'b1);
    inst_arvalid = 1'b1; inst_araddr = 32'h0000_8000; inst_arlen = 8'd0;
    txn(1'b0, 32'h0000_8000, 32'hCAFE_F00D);
    inst_arvalid = 1'b0;
    #1;
    chk1("t5_rd_err_sticky", rd_err, 1'b1);

    // Reset in the middle of a MEM burst
    mem_arvalid = 1'b1; mem_araddr = 32'h0000_9000; mem_arlen = 8'd3;
    tick();
    mem_arvalid = 1'b0;
    tick();
    s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = 32'h55; mem_rready = 1'b1;
    #1;
    chk1("t6_mem_rvalid", mem_rvalid, 1'b1);
    tick();
    cpu_reset = 1'b1;
    tick();
    chk1("t6_s_arvalid", s_arvalid, 1'b0);
    chk1("t6_rd_err", rd_err, 1'b0);
    chk1("t6_inst_rvalid", inst_rvalid, 1'b0);
    chk1("t6_mem_rvalid_idle", mem_rvalid, 1'b0);
    chk1("t6_s_rready", s_rready, 1'b0);
    cpu_reset = 1'b0; s_rvalid = 1'b0;

    // arlen=0 but the first beat lacks rlast
    inst_arvalid = 1'b1; inst_araddr = 32'h0000_A000; inst_arlen = 8'd0;
    tick();
    inst_arvalid = 1'b0;
    tick();
    s_rvalid = 1'b1; s_rlast = 1'b0; inst_rready = 1'b1;
    tick();
    #1;
    chk1("t7_rd_err", rd_err, 1'b1);
    s_rlast = 1'b1;
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    chk1("t7_idle_rvalid", inst_rvalid, 1'b0);
    chk1("t7_rd_err_sticky", rd_err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master to one-slave AXI4 read-channel arbiter that sits directly downstream of the CPU wrapper.
- It merges the instruction-fetch AR/R pair (cpu_inst_*) and the data AR/R pair (cpu_mem_*) onto the single read port of the memory crossbar.
- Round-robin grant, one outstanding transaction at a time; the grant is held from AR issue until the last R beat.
- A beat counter checks rlast against arlen and raises a sticky protocol-error flag.

Parameters:
ADDR_WIDTH, 32, AR address width
DATA_WIDTH, 32, R data width

Ports:
cpu_clk  in  1  clock
cpu_reset  in  1  synchronous, active-high reset
inst_araddr/inst_arsize/inst_arburst/inst_arlen  in  ADDR_WIDTH/3/2/8  instruction master AR payload
inst_arvalid  in  1 ; inst_arready  out  1  instruction master AR handshake
inst_rdata  out  DATA_WIDTH ; inst_rvalid  out  1 ; inst_rlast  out  1 ; inst_rready  in  1  instruction master R channel
mem_araddr/mem_arsize/mem_arburst/mem_arlen  in  ADDR_WIDTH/3/2/8  data master AR payload
mem_arvalid  in  1 ; mem_arready  out  1  data master AR handshake
mem_rdata  out  DATA_WIDTH ; mem_rvalid  out  1 ; mem_rlast  out  1 ; mem_rready  in  1  data master R channel
s_araddr/s_arsize/s_arburst/s_arlen  out  ADDR_WIDTH/3/2/8  slave-side AR payload (registered)
s_arvalid  out  1 ; s_arready  in  1  slave-side AR handshake
s_rdata  in  DATA_WIDTH ; s_rvalid  in  1 ; s_rlast  in  1 ; s_rready  out  1  slave-side R channel
rd_err  out  1  sticky rlast/arlen mismatch flag

Behaviour:
- Clock and reset: single clock cpu_clk; cpu_reset is synchronous and active-high.
- Reset: state=IDLE; s_arvalid=0; s_araddr/s_arsize/s_arburst/s_arlen=0; last_grant=MEM, so INST wins first; beat_cnt=0; rd_err=0.
- FSM states: IDLE, AR, R.
- IDLE:
  - Grant selection (combinational): if only one arvalid, grant that master. If both, grant the master not equal to last_grant.
  - The granted master's arready=1 (combinational, IDLE only). The other master's arready=0.
  - On the handshake, register the granted payload into s_ar*, set grant, set s_arvalid=1, and go to AR. This is one cycle of AR latency.
  - arready is never asserted outside IDLE.
- AR:
  - s_arvalid held at 1 with a stable payload until s_arready=1.
  - On the handshake: s_arvalid<=0, beat_cnt<=0, go to R.
  - Master arvalids are ignored while in AR.
- R:
  - Granted master: <g>_rdata=s_rdata, <g>_rvalid=s_rvalid, <g>_rlast=s_rlast, s_rready=<g>_rready (all combinational).
  - Non-granted master: rvalid=0, rlast=0, rdata=0.
  - Each beat with s_rvalid&s_rready increments beat_cnt (8-bit, wraps at 255).
  - On a beat with s_rlast=1: last_grant<=grant, go to IDLE. New arbitration happens in the next cycle, so there is one idle bubble.
- Outside R: s_rready=0 and both master rvalid=0. A stray s_rvalid is dropped and not consumed.
- rd_err (sticky until reset) is set when either:
  - s_rlast=1 on a beat where beat_cnt!=s_arlen (latched value), or
  - a beat with s_rlast=0 arrives when beat_cnt==s_arlen.
  - The FSM still obeys s_rlast for its state transition.
- Simultaneous arvalid from both masters on consecutive transactions: grants strictly alternate INST, MEM, INST, ...
- A master deasserting arvalid before arready is legal here. Only the handshake cycle's payload is captured.
- Reset mid-transaction returns to IDLE in the next cycle. Outstanding slave beats are not drained; system reset covers the slave as well.

Test Plan:
- Reset then a single INST read: araddr=0x0000_1000, arlen=0 -> inst_arready pulses 1 cycle; s_araddr=0x1000 with s_arvalid the next cycle; slave returns 0xDEADBEEF with rlast -> inst_rdata=0xDEADBEEF, inst_rvalid=1, mem_rvalid=0, rd_err=0.
- Both arvalid held high for 4 transactions -> grant order INST, MEM, INST, MEM; each R beat is routed only to its owner.
- s_arready held low for 5 cycles -> s_arvalid stays 1 and s_araddr stays stable; no arready is given to either master.
- MEM burst arlen=3 with beats 0x10..0x13 and rlast on the 4th beat; mem_rready toggles 1,0,1 -> exactly 4 beats delivered in order, s_rready mirrors mem_rready, rd_err=0.
- arlen=3 but rlast on the 2nd beat -> rd_err=1 and stays 1; FSM returns to IDLE and the next INST read completes.
- cpu_reset asserted in R mid-burst -> next cycle: state IDLE, s_arvalid=0, rd_err=0, both rvalid=0.
